// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-memory port arbiter between CPU load/store path and boot-loader writes
// Defining ARB_PERF_EN adds saturating perf_cpu_stall / perf_ld_wait counters.
module mem_port_arbiter #(
    parameter int MAX_CPU_STREAK = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
`ifdef ARB_PERF_EN
    output logic [15:0] perf_cpu_stall,
    output logic [15:0] perf_ld_wait,
`endif
    output logic        err
);
    typedef enum logic [1:0] {IDLE, CPU_BUSY, LD_BUSY, ACK} state_e;
    localparam int SW = $clog2(MAX_CPU_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic          cpu_ack_q, cpu_ack_d, ld_ack_q, ld_ack_d, err_q, err_d;
    logic          cpu_req, busy, grant_cpu, grant_ld, tmo_hit, xfer_done;

    assign cpu_req   = cpu_rd | cpu_wr;
    assign busy      = (state_q == CPU_BUSY) || (state_q == LD_BUSY);
    // A waiting loader wins a tie only once the CPU has used up its streak allowance.
    assign grant_cpu = (state_q == IDLE) && cpu_req &&
                       (!ld_req || (streak_q < SW'(MAX_CPU_STREAK)));
    assign grant_ld  = (state_q == IDLE) && ld_req && !grant_cpu;
    assign tmo_hit   = busy && !mem_ready && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign xfer_done = busy && (mem_ready || tmo_hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu)     state_d = CPU_BUSY;
                else if (grant_ld) state_d = LD_BUSY;
            end
            CPU_BUSY, LD_BUSY: if (xfer_done) state_d = ACK;
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        ld_ack_d    = 1'b0;
        err_d       = err_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        if (grant_cpu) begin
            mem_wr_d    = cpu_wr;
            mem_rd_d    = ~cpu_wr;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_size_d  = cpu_size;
            tmo_d       = '0;
            if (!ld_req)
                streak_d = '0;
            else if (streak_q != SW'(MAX_CPU_STREAK))
                streak_d = streak_q + SW'(1);
        end else if (grant_ld) begin
            mem_wr_d    = 1'b1;
            mem_rd_d    = 1'b0;
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
            mem_size_d  = 2'b11;
            tmo_d       = '0;
            streak_d    = '0;
        end else if (xfer_done) begin
            mem_rd_d  = 1'b0;
            mem_wr_d  = 1'b0;
            cpu_ack_d = (state_q == CPU_BUSY);
            ld_ack_d  = (state_q == LD_BUSY);
            if (tmo_hit) begin
                err_d = 1'b1;
                if (state_q == CPU_BUSY) cpu_rdata_d = '0;
            end else if ((state_q == CPU_BUSY) && mem_rd_q) begin
                cpu_rdata_d = mem_rdata;
            end
        end else if (busy) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign err       = err_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

`ifdef ARB_PERF_EN
    logic [15:0] perf_stall_q, perf_wait_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (cpu_stall && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
            if (ld_req && !ld_ack_q && (perf_wait_q != 16'hFFFF))
                perf_wait_q <= perf_wait_q + 16'd1;
        end
    end

    assign perf_cpu_stall = perf_stall_q;
    assign perf_ld_wait   = perf_wait_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int MAXS = 2;
    localparam int TMO  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, ld_req = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ld_ack, mem_rd, mem_wr, mem_ready, err;
    logic [1:0]  mem_size;
`ifdef ARB_PERF_EN
    logic [15:0] perf_cpu_stall, perf_ld_wait;
`endif

    mem_port_arbiter #(.MAX_CPU_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef ARB_PERF_EN
        .perf_cpu_stall(perf_cpu_stall), .perf_ld_wait(perf_ld_wait),
`endif
        .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // memory responder: mem_ready after force_dly strobe cycles (0 = never, -1 = random)
    int          force_dly = 1;
    logic        fix_en = 1'b0;
    logic [31:0] fix_data = '0;
    logic        spur_en = 1'b0;

    initial begin : responder
        int cnt;
        int dly;
        cnt = 0;
        dly = 1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && (mem_rd || mem_wr)) begin
                cnt++;
                if (cnt == 1) dly = (force_dly >= 0) ? force_dly : int'($urandom_range(1, 5));
                mem_ready = (cnt == dly);
                mem_rdata = fix_en ? fix_data : $urandom;
            end else begin
                cnt = 0;
                mem_ready = spur_en && !reset && ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // transaction-level model: owner 0 none / 1 cpu / 2 loader; m_ack = who is acked this cycle
    int          m_owner, m_ack, m_waited, m_streak;
    logic        m_wr, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
`ifdef ARB_PERF_EN
    int          m_pstall, m_pwait;
`endif

    initial begin : scoreboard
        int   nxt;
        logic e_rd, e_wr, e_stall;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_owner = 0; m_ack = 0; m_waited = 0; m_streak = 0;
                m_rdata = '0; m_err = 1'b0; m_wr = 1'b0;
                m_addr = '0; m_wdata = '0; m_size = '0;
`ifdef ARB_PERF_EN
                m_pstall = 0; m_pwait = 0;
`endif
            end else begin
                e_rd    = (m_owner == 1) && !m_wr;
                e_wr    = (m_owner == 2) || ((m_owner == 1) && m_wr);
                e_stall = (cpu_rd || cpu_wr) && (m_ack != 1);
                chk("mem_rd", 32'(mem_rd), 32'(e_rd));
                chk("mem_wr", 32'(mem_wr), 32'(e_wr));
                if (m_owner != 0) begin
                    chk("mem_addr", mem_addr, m_addr);
                    chk("mem_wdata", mem_wdata, m_wdata);
                    chk("mem_size", 32'(mem_size), 32'(m_size));
                end
                chk("cpu_ack", 32'(cpu_ack), 32'(m_ack == 1));
                chk("ld_ack", 32'(ld_ack), 32'(m_ack == 2));
                chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
                chk("cpu_rdata", cpu_rdata, m_rdata);
                chk("err", 32'(err), 32'(m_err));
`ifdef ARB_PERF_EN
                chk("perf_cpu_stall", 32'(perf_cpu_stall), 32'(m_pstall));
                chk("perf_ld_wait", 32'(perf_ld_wait), 32'(m_pwait));
                if (e_stall && m_pstall < 65535) m_pstall++;
                if (ld_req && m_ack != 2 && m_pwait < 65535) m_pwait++;
`endif
                nxt = 0;
                if (m_owner != 0) begin
                    if (mem_ready) begin
                        if (m_owner == 1 && !m_wr) m_rdata = mem_rdata;
                        nxt = m_owner;
                        m_owner = 0;
                    end else begin
                        m_waited++;
                        if (m_waited >= TMO) begin
                            m_err = 1'b1;
                            if (m_owner == 1) m_rdata = '0;
                            nxt = m_owner;
                            m_owner = 0;
                        end
                    end
                end else if (m_ack == 0) begin
                    if ((cpu_rd || cpu_wr) && (!ld_req || m_streak < MAXS)) begin
                        m_owner = 1; m_wr = cpu_wr; m_addr = cpu_addr;
                        m_wdata = cpu_wdata; m_size = cpu_size; m_waited = 0;
                        m_streak = ld_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                    end else if (ld_req) begin
                        m_owner = 2; m_wr = 1'b1; m_addr = ld_addr;
                        m_wdata = ld_wdata; m_size = 2'b11; m_waited = 0; m_streak = 0;
                    end
                end
                m_ack = nxt;
            end
        end
    end

    initial begin : main
        int          rd_cyc, stall_cyc, ack_at, nack_l, nack_c;
        logic        wr_seen, prev_s, err_at, cs, ls;
        logic [31:0] rd_val;
        int          seq[$];
        int          exp_seq[6];
        exp_seq = '{1, 1, 2, 1, 1, 2};
        rd_val = '0;
        err_at = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_ld_ack", 32'(ld_ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // CPU read with 3-cycle memory latency
        @(posedge clock); #1;
        force_dly = 3; fix_en = 1'b1; fix_data = 32'hDEADBEEF;
        cpu_rd = 1'b1; cpu_addr = 32'h10; cpu_size = 2'b10;
        rd_cyc = 0; stall_cyc = 0; ack_at = -1;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clock);
            if (mem_rd) begin rd_cyc++; chk("rd_addr", mem_addr, 32'h10); end
            if (cpu_stall) stall_cyc++;
            if (cpu_ack) begin ack_at = i; rd_val = cpu_rdata; end
        end
        chk("rd_ack_cycle", 32'(ack_at), 32'd4);
        chk("rd_strobe_cycles", 32'(rd_cyc), 32'd3);
        chk("rd_stall_cycles", 32'(stall_cyc), 32'd4);
        chk("rd_data", rd_val, 32'hDEADBEEF);
        @(posedge clock); #1;
        cpu_rd = 1'b0; fix_en = 1'b0;

        // loader word write
        @(posedge clock); #1;
        force_dly = 1; ld_req = 1'b1; ld_addr = 32'h0040_0000; ld_wdata = 32'h1234_5678;
        nack_l = 0; nack_c = 0; wr_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_wr && !wr_seen) begin
                wr_seen = 1'b1;
                chk("ld_addr", mem_addr, 32'h0040_0000);
                chk("ld_wdata", mem_wdata, 32'h1234_5678);
                chk("ld_size", 32'(mem_size), 32'h3);
            end
            nack_l += int'(ld_ack);
            nack_c += int'(cpu_ack);
            if (ld_ack) begin @(posedge clock); #1; ld_req = 1'b0; end
        end
        chk("ld_wr_seen", 32'(wr_seen), 32'h1);
        chk("ld_ack_pulses", 32'(nack_l), 32'd1);
        chk("ld_no_cpu_ack", 32'(nack_c), 32'd0);

        // timeout, then a normal access
        @(posedge clock); #1;
        force_dly = 0; cpu_rd = 1'b1; cpu_addr = 32'h20;
        rd_cyc = 0; ack_at = -1;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clock);
            if (mem_rd) rd_cyc++;
            if (cpu_ack) begin ack_at = i; rd_val = cpu_rdata; err_at = err; end
        end
        chk("tmo_ack_cycle", 32'(ack_at), 32'd5);
        chk("tmo_strobe_cycles", 32'(rd_cyc), 32'd4);
        chk("tmo_rdata", rd_val, 32'h0);
        chk("tmo_err", 32'(err_at), 32'h1);
        @(posedge clock); #1;
        cpu_rd = 1'b0; force_dly = 2;
        @(posedge clock); #1;
        cpu_wr = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'hA5A5_0001; cpu_size = 2'b11;
        ack_at = -1;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clock);
            if (cpu_ack) ack_at = i;
        end
        chk("post_tmo_ack_cycle", 32'(ack_at), 32'd3);
        chk("err_sticky", 32'(err), 32'h1);
        @(posedge clock); #1;
        cpu_wr = 1'b0;

        // continuous contention: grant order with MAX_CPU_STREAK=2
        @(posedge clock); #1;
        force_dly = 1; cpu_rd = 1'b1; cpu_addr = 32'h40; ld_req = 1'b1; ld_addr = 32'h80;
        seq.delete();
        prev_s = 1'b0;
        for (int i = 0; i < 60 && seq.size() < 6; i++) begin
            @(negedge clock);
            if ((mem_rd || mem_wr) && !prev_s) seq.push_back(mem_wr ? 2 : 1);
            prev_s = mem_rd || mem_wr;
        end
        for (int j = 0; j < 6; j++)
            chk($sformatf("streak_grant_%0d", j), 32'((j < seq.size()) ? seq[j] : 0), 32'(exp_seq[j]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (cpu_ack || ld_ack) break;
        end
        @(posedge clock); #1;
        cpu_rd = 1'b0; ld_req = 1'b0;

        // reset in the middle of a CPU access
        @(posedge clock); #1;
        force_dly = 0; cpu_rd = 1'b1; cpu_addr = 32'h30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_rd) break;
        end
        chk("pre_rst_strobe", 32'(mem_rd), 32'h1);
        @(posedge clock); #3;
        reset = 1'b1; force_dly = 2;
        #1;
        chk("rst_async_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_clears_err", 32'(err), 32'h0);
        @(negedge clock);
        chk("rst_no_ack", 32'(cpu_ack), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        rd_cyc = 0; ack_at = -1;
        for (int i = 0; i < 12 && ack_at < 0; i++) begin
            @(negedge clock);
            if (mem_rd) rd_cyc++;
            if (cpu_ack) ack_at = i;
        end
        chk("post_rst_ack_cycle", 32'(ack_at), 32'd3);
        chk("post_rst_strobe_cycles", 32'(rd_cyc), 32'd2);
        @(posedge clock); #1;
        cpu_rd = 1'b0;

        // randomized traffic against the model
        force_dly = -1; spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            cs = cpu_ack; ls = ld_ack;
            @(posedge clock); #1;
            if (((cpu_rd || cpu_wr) && cs) || (!(cpu_rd || cpu_wr) && $urandom_range(0, 2) == 0)) begin
                if ((cpu_rd || cpu_wr) && $urandom_range(0, 1) == 0) begin
                    cpu_rd = 1'b0; cpu_wr = 1'b0;
                end else begin
                    {cpu_wr, cpu_rd} = 2'($urandom_range(1, 3));
                    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 3));
                end
            end
            if ((ld_req && ls) || (!ld_req && $urandom_range(0, 2) == 0)) begin
                if (ld_req && $urandom_range(0, 1) == 0) begin
                    ld_req = 1'b0;
                end else begin
                    ld_req = 1'b1; ld_addr = $urandom; ld_wdata = $urandom;
                end
            end
        end
        spur_en = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; ld_req = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port (RAM plus memory-mapped serial buffer) between two requesters: the single-cycle CPU load/store path and a serial boot-loader write port. Sits between the processor datapath (ALU result/rs2 data) and data_memory. Stalls the CPU while the memory is busy or the loader owns the port, guarantees the loader bounded wait, and aborts hung transfers.

Parameters:
MAX_CPU_STREAK, 8, consecutive CPU grants allowed while the loader is waiting before the loader is forced a grant (must be >=1)
TIMEOUT_CYCLES, 255, cycles an access may wait for mem_ready before it is aborted (must be >=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_rd  in  1  CPU load request (level, held until cpu_ack)
cpu_wr  in  1  CPU store request (level, held until cpu_ack)
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU store data
cpu_size  in  2  access size code, forwarded unchanged
cpu_rdata  out  32  registered load data, valid with cpu_ack, held until next CPU completion
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  combinational: (cpu_rd|cpu_wr) & ~cpu_ack
ld_req  in  1  loader write request (level, held until ld_ack)
ld_addr  in  32  loader byte address
ld_wdata  in  32  loader word data (size forced to word code 2'b11)
ld_ack  out  1  one-cycle completion pulse
mem_rd  out  1  registered read strobe to data_memory
mem_wr  out  1  registered write strobe to data_memory
mem_addr  out  32  registered address
mem_wdata  out  32  registered write data
mem_size  out  2  registered size code
mem_rdata  in  32  data_memory read data
mem_ready  in  1  one-cycle pulse: current access complete
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async): state IDLE; all outputs 0; streak and timeout counters 0. Reset mid-access drops mem_rd/mem_wr immediately; no ack is issued for the aborted access.
- States: IDLE, CPU_BUSY, LD_BUSY, ACK.
- IDLE: both idle -> stay. Only CPU requests -> CPU_BUSY. Only loader -> LD_BUSY. Both -> CPU_BUSY if streak < MAX_CPU_STREAK, else LD_BUSY.
- Entering a BUSY state: mem_* registered from the winner on that edge; cpu_wr=1 drives mem_wr, otherwise mem_rd (cpu_rd and cpu_wr both high is treated as a write). Loader always drives mem_wr.
- BUSY: mem_* held stable. On mem_ready: drop strobes, assert the owner's ack for exactly the next cycle, and go to ACK. CPU read captures mem_rdata into cpu_rdata on the same edge.
- Minimum latency: request sampled at edge N, strobe visible after N, mem_ready in cycle N+1, ack high in cycle N+2.
- ACK: one idle cycle so the requester can drop or change its request, then IDLE. Requests are not sampled in ACK.
- Streak: incremented on a CPU grant while ld_req=1; reset to 0 on a loader grant or whenever ld_req=0 at grant time; saturates at MAX_CPU_STREAK.
- Timeout: counter cleared on BUSY entry, incremented each BUSY cycle without mem_ready. On reaching TIMEOUT_CYCLES: drop strobes, set err, pulse the owner's ack (cpu_rdata forced to 0), go to ACK.
- mem_ready outside BUSY is ignored.

Optional Feature:
ARB_PERF_EN: when defined, adds outputs perf_cpu_stall[15:0] and perf_ld_wait[15:0]. perf_cpu_stall counts cycles with cpu_stall=1; perf_ld_wait counts cycles with ld_req=1 and ld_ack=0. Both saturate at 16'hFFFF and are cleared by reset. When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CPU read of 0x00000010, memory returns 0xDEADBEEF with mem_ready 3 cycles after the strobe -> mem_rd held 3 cycles; cpu_ack one cycle later; cpu_rdata=0xDEADBEEF; cpu_stall high until the ack cycle.
- Loader write of 0x00400000 with 0x12345678 -> mem_wr=1, mem_size=2'b11, mem_wdata=0x12345678; ld_ack one pulse; cpu_ack stays 0.
- CPU and loader request continuously with MAX_CPU_STREAK=2 -> grant order CPU, CPU, LD, CPU, CPU, LD...
- mem_ready never asserted with TIMEOUT_CYCLES=4 -> abort after 4 BUSY cycles; err=1 (sticky); cpu_ack pulses with cpu_rdata=0; next request is served normally.
- Reset asserted mid-CPU_BUSY -> mem_rd drops asynchronously; no ack; after release, a pending request starts from IDLE.
- With ARB_PERF_EN defined, a 5-cycle CPU stall -> perf_cpu_stall=5; held counts saturate at 0xFFFF.
